// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared state type, frame constants and cycle helpers for the PS/2 blocks
//
// Purpose: common definitions for the PS/2 host transmitter and the keyboard
//          receiver. No ports (package).

package ps2_pkg;

  // Host-to-device transmitter states.
  typedef enum logic [2:0] {
    TX_IDLE    = 3'd0,
    TX_INHIBIT = 3'd1,
    TX_REQ     = 3'd2,
    TX_SHIFT   = 3'd3,
    TX_RELEASE = 3'd4
  } ps2_tx_state_e;

  // Falling device-clock edges in one host-to-device frame.
  localparam int unsigned PS2_DATA_EDGES  = 8;
  localparam int unsigned PS2_PARITY_EDGE = 9;
  localparam int unsigned PS2_STOP_EDGE   = 10;
  localparam int unsigned PS2_FRAME_EDGES = 11;

  // Released open-drain lines read as 1 through the pull-ups.
  localparam logic PS2_LINE_IDLE = 1'b1;

  // Whole-MHz clock assumed: cycles = (Hz / 1e6) * microseconds.
  function automatic int unsigned ps2_us_to_cycles(input int unsigned clk_freq,
                                                   input int unsigned us);
    return (clk_freq / 1_000_000) * us;
  endfunction

  // Bits needed to hold values 0..max_val.
  function automatic int unsigned ps2_cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// rtl/ps2_line_sync.sv - 2-flop synchronizer and falling-edge detect for the PS/2 lines
//
// Purpose: brings the raw PS/2 clock and data pin levels into the clk domain
//          and flags their falling edges (sync'd value was 1, now 0).
// Ports:
//   clk       in  system clock
//   rst_n     in  asynchronous active-low reset
//   clk_in    in  raw PS/2 clock pin level (asynchronous)
//   data_in   in  raw PS/2 data pin level (asynchronous)
//   clk_sync  out synchronized clock line
//   data_sync out synchronized data line
//   clk_fall  out one-cycle falling-edge strobe on the clock line
//   data_fall out one-cycle falling-edge strobe on the data line

module ps2_line_sync
  import ps2_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clk_in,
  input  logic data_in,
  output logic clk_sync,
  output logic data_sync,
  output logic clk_fall,
  output logic data_fall
);

  // Bit 1 = clock line, bit 0 = data line.
  logic [1:0] meta_q, meta_d;
  logic [1:0] sync_q, sync_d;
  logic [1:0] prev_q, prev_d;

  always_comb begin
    meta_d = {clk_in, data_in};
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Reset to the idle (pulled-up) level so release of reset never looks
  // like a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= {2{PS2_LINE_IDLE}};
      sync_q <= {2{PS2_LINE_IDLE}};
      prev_q <= {2{PS2_LINE_IDLE}};
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign clk_sync  = sync_q[1];
  assign data_sync = sync_q[0];
  assign clk_fall  = prev_q[1] & ~sync_q[1];
  assign data_fall = prev_q[0] & ~sync_q[0];

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - host-to-device PS/2 command transmitter
//
// Purpose: accepts one command byte per tx_valid/tx_ready handshake and sends
//          it to the keyboard: clock inhibit, request-to-send, 8 data bits LSB
//          first, odd parity, stop, then checks the device acknowledge.
// Ports:
//   clk          in  system clock (fast_clk)
//   reset        in  asynchronous active-low reset
//   tx_data      in  command byte
//   tx_valid     in  tx_data is valid
//   tx_ready     out block can accept a byte (IDLE)
//   ps2_clk_in   in  raw PS/2 clock pin level
//   ps2_data_in  in  raw PS/2 data pin level
//   ps2_clk_oe   out 1 pulls the clock line low
//   ps2_data_oe  out 1 pulls the data line low
//   tx_active    out frame in progress; receiver ignores the lines
//   done         out one-cycle pulse, frame acknowledged
//   error        out one-cycle pulse, timeout or missing acknowledge

module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 48_000_000,
  parameter int unsigned INHIBIT_US = 100,
  parameter int unsigned TIMEOUT_US = 15000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       tx_active,
  output logic       done,
  output logic       error
);

  localparam int unsigned INHIBIT_CYCLES = ps2_us_to_cycles(CLK_FREQ, INHIBIT_US);
  localparam int unsigned TIMEOUT_CYCLES = ps2_us_to_cycles(CLK_FREQ, TIMEOUT_US);
  // One counter serves both the inhibit period and the timeout.
  localparam int unsigned TMR_W = ps2_cnt_width(
      (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES);
  localparam logic [TMR_W-1:0] INHIBIT_LOAD = TMR_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

  logic clk_sync;
  logic data_sync;
  logic clk_fall;
  logic unused_data_fall;

  ps2_line_sync u_line_sync (
    .clk       (clk),
    .rst_n     (reset),
    .clk_in    (ps2_clk_in),
    .data_in   (ps2_data_in),
    .clk_sync  (clk_sync),
    .data_sync (data_sync),
    .clk_fall  (clk_fall),
    .data_fall (unused_data_fall)
  );

  ps2_tx_state_e state_q, state_d;
  logic [TMR_W-1:0] cnt_q, cnt_d;
  logic [3:0]       edge_cnt_q, edge_cnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             parity_q, parity_d;
  logic             ack_q, ack_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

  logic [3:0] edge_n;
  logic       timer_zero;

  assign edge_n     = edge_cnt_q + 4'd1;
  assign timer_zero = (cnt_q == '0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    edge_cnt_d = edge_cnt_q;
    shreg_d    = shreg_q;
    parity_d   = parity_q;
    ack_d      = ack_q;
    clk_oe_d   = clk_oe_q;
    data_oe_d  = data_oe_q;
    done_d     = 1'b0;
    error_d    = 1'b0;

    unique case (state_q)
      TX_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (tx_valid) begin
          shreg_d   = tx_data;
          parity_d  = ~^tx_data;
          cnt_d     = INHIBIT_LOAD;
          clk_oe_d  = 1'b1;
          // A one-cycle inhibit is also its own last cycle.
          data_oe_d = (INHIBIT_CYCLES == 1);
          state_d   = TX_INHIBIT;
        end
      end

      TX_INHIBIT: begin
        if (timer_zero) begin
          clk_oe_d   = 1'b0;
          data_oe_d  = 1'b1;
          cnt_d      = TIMEOUT_LOAD;
          edge_cnt_d = 4'd0;
          state_d    = TX_REQ;
        end else begin
          cnt_d     = cnt_q - TMR_W'(1);
          clk_oe_d  = 1'b1;
          // Start bit goes out during the final inhibit cycle.
          data_oe_d = (cnt_q == TMR_W'(1));
        end
      end

      TX_REQ: begin
        // The first device falling edge is edge 1: present data bit 0.
        if (clk_fall) begin
          data_oe_d  = ~shreg_q[0];
          shreg_d    = {1'b0, shreg_q[7:1]};
          edge_cnt_d = 4'd1;
          cnt_d      = TIMEOUT_LOAD;
          state_d    = TX_SHIFT;
        end else if (timer_zero) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          error_d   = 1'b1;
          state_d   = TX_IDLE;
        end else begin
          cnt_d = cnt_q - TMR_W'(1);
        end
      end

      TX_SHIFT: begin
        if (clk_fall) begin
          cnt_d      = TIMEOUT_LOAD;
          edge_cnt_d = edge_n;
          if (edge_n <= 4'(PS2_DATA_EDGES)) begin
            data_oe_d = ~shreg_q[0];
            shreg_d   = {1'b0, shreg_q[7:1]};
          end else if (edge_n == 4'(PS2_PARITY_EDGE)) begin
            data_oe_d = ~parity_q;
          end else if (edge_n == 4'(PS2_STOP_EDGE)) begin
            data_oe_d = 1'b0;
          end else begin
            // Device holds data low across this edge to acknowledge.
            ack_d     = ~data_sync;
            data_oe_d = 1'b0;
            state_d   = TX_RELEASE;
          end
        end else if (timer_zero) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          error_d   = 1'b1;
          state_d   = TX_IDLE;
        end else begin
          cnt_d = cnt_q - TMR_W'(1);
        end
      end

      TX_RELEASE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (clk_sync && data_sync) begin
          done_d  = ack_q;
          error_d = ~ack_q;
          state_d = TX_IDLE;
        end else if (clk_fall) begin
          cnt_d = TIMEOUT_LOAD;
        end else if (timer_zero) begin
          error_d = 1'b1;
          state_d = TX_IDLE;
        end else begin
          cnt_d = cnt_q - TMR_W'(1);
        end
      end

      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = TX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= TX_IDLE;
      cnt_q      <= '0;
      edge_cnt_q <= 4'd0;
      shreg_q    <= 8'd0;
      parity_q   <= 1'b0;
      ack_q      <= 1'b0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      edge_cnt_q <= edge_cnt_d;
      shreg_q    <= shreg_d;
      parity_q   <= parity_d;
      ack_q      <= ack_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign tx_ready    = (state_q == TX_IDLE);
  assign tx_active   = (state_q != TX_IDLE);
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign done        = done_q;
  assign error       = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - directed testbench for ps2_host_tx with a PS/2 device model

module tb_ps2_host_tx;

  // 4 MHz keeps every frame short: inhibit 400 cycles, timeout 8000 cycles.
  localparam int unsigned TB_CLK_FREQ = 4_000_000;
  localparam int unsigned TB_INH_US   = 100;
  localparam int unsigned TB_TO_US    = 2000;
  localparam int          INH_CYC     = 400;
  localparam int          TO_CYC      = 8000;
  // 12.5 kHz device clock: 80 us period, 160 cycles per half at 4 MHz.
  localparam int          HALF        = 160;

  // {stop, parity, data[7:0], start} as the device samples them.
  localparam logic [10:0] FR_ED = 11'b11111011010;
  localparam logic [10:0] FR_01 = 11'b10000000010;
  localparam logic [10:0] FR_00 = 11'b11000000000;
  localparam logic [10:0] FR_FF = 11'b11111111110;
  localparam logic [10:0] FR_F4 = 11'b10111101000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       clk_oe;
  logic       data_oe;
  logic       tx_active;
  logic       done;
  logic       error;
  logic       dev_clk_low;
  logic       dev_data_low;
  logic       clk_line;
  logic       data_line;

  assign clk_line  = ~(clk_oe | dev_clk_low);
  assign data_line = ~(data_oe | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .CLK_FREQ   (TB_CLK_FREQ),
    .INHIBIT_US (TB_INH_US),
    .TIMEOUT_US (TB_TO_US)
  ) dut (
    .clk         (clk),
    .reset       (rst_n),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .ps2_clk_in  (clk_line),
    .ps2_data_in (data_line),
    .ps2_clk_oe  (clk_oe),
    .ps2_data_oe (data_oe),
    .tx_active   (tx_active),
    .done        (done),
    .error       (error)
  );

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int both_cnt = 0;
  int ready_viol = 0;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (error) err_cnt++;
    if (done && error) both_cnt++;
    if (tx_active && tx_ready) ready_viol++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic present(input logic [7:0] b, input bit hold);
    int n;
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    n = 0;
    while (!tx_ready && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check_eq("accept_wait", 32'(n < 20000), 1);
    @(negedge clk);
    if (!hold) tx_valid = 1'b0;
    check_eq("clk_oe_after_accept", clk_oe, 1);
    check_eq("ready_low_after_accept", tx_ready, 0);
  endtask

  task automatic check_inhibit();
    int   n;
    logic first_d;
    logic last_d;
    n = 0;
    first_d = data_oe;
    last_d  = data_oe;
    while (clk_oe && n < INH_CYC + 100) begin
      last_d = data_oe;
      n++;
      @(negedge clk);
    end
    check_eq("inhibit_len", n, INH_CYC);
    check_eq("start_bit_early", first_d, 0);
    check_eq("start_bit_last_cycle", last_d, 1);
    check_eq("rts_data_oe", data_oe, 1);
  endtask

  // mode 0: acknowledge, 1: no acknowledge, 2: reset at edge 5
  task automatic device_frame(input int mode, output logic [10:0] frame);
    frame = '0;
    frame[0] = data_line;
    for (int k = 1; k <= 11; k++) begin
      if (k == 11) begin
        repeat (HALF / 2) @(negedge clk);
        dev_data_low = (mode == 0);
      end
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b1;
      if (mode == 2 && k == 5) begin
        repeat (10) @(negedge clk);
        check_eq("pre_reset_data_oe", data_oe, 1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("reset_clk_oe", clk_oe, 0);
        check_eq("reset_data_oe", data_oe, 0);
        check_eq("reset_active", tx_active, 0);
        dev_clk_low = 1'b0;
        return;
      end
      repeat (HALF) @(negedge clk);
      if (k <= 10) frame[k] = data_line;
      dev_clk_low = 1'b0;
    end
    repeat (HALF / 2) @(negedge clk);
    dev_data_low = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (tx_active && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check_eq("frame_end", tx_active, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [10:0] fr;
    logic [10:0] fr2;
    int d0;
    int e0;
    int n;

    rst_n        = 1'b0;
    tx_valid     = 1'b0;
    tx_data      = 8'h00;
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("rst_tx_ready", tx_ready, 1);
    check_eq("rst_tx_active", tx_active, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_error", error, 0);
    check_eq("rst_clk_oe", clk_oe, 0);
    check_eq("rst_data_oe", data_oe, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 0xED with acknowledge
    d0 = done_cnt; e0 = err_cnt;
    present(8'hED, 1'b0);
    check_inhibit();
    device_frame(0, fr);
    wait_idle();
    check_eq("frame_ED", fr, FR_ED);
    check_eq("done_ED", done_cnt - d0, 1);
    check_eq("err_ED", err_cnt - e0, 0);
    check_eq("ready_ED", tx_ready, 1);

    // 0x01 -> parity 0
    d0 = done_cnt; e0 = err_cnt;
    present(8'h01, 1'b0);
    check_inhibit();
    device_frame(0, fr);
    wait_idle();
    check_eq("frame_01", fr, FR_01);
    check_eq("parity_01", fr[9], 0);
    check_eq("done_01", done_cnt - d0, 1);

    // 0x00 -> parity 1
    d0 = done_cnt; e0 = err_cnt;
    present(8'h00, 1'b0);
    check_inhibit();
    device_frame(0, fr);
    wait_idle();
    check_eq("frame_00", fr, FR_00);
    check_eq("parity_00", fr[9], 1);
    check_eq("done_00", done_cnt - d0, 1);

    // device never clocks: timeout measured from REQ entry
    d0 = done_cnt; e0 = err_cnt;
    present(8'h55, 1'b0);
    check_inhibit();
    n = 0;
    while (!error && n < TO_CYC + 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("timeout_len", n, TO_CYC);
    check_eq("timeout_clk_oe", clk_oe, 0);
    check_eq("timeout_data_oe", data_oe, 0);
    check_eq("timeout_ready", tx_ready, 1);
    repeat (2) @(negedge clk);
    check_eq("timeout_err", err_cnt - e0, 1);
    check_eq("timeout_done", done_cnt - d0, 0);

    // no acknowledge at edge 11
    d0 = done_cnt; e0 = err_cnt;
    present(8'hED, 1'b0);
    check_inhibit();
    device_frame(1, fr);
    wait_idle();
    check_eq("frame_noack", fr, FR_ED);
    check_eq("noack_err", err_cnt - e0, 1);
    check_eq("noack_done", done_cnt - d0, 0);

    // reset mid-frame, then a fresh 0xFF
    d0 = done_cnt; e0 = err_cnt;
    present(8'hED, 1'b0);
    check_inhibit();
    device_frame(2, fr);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_reset_ready", tx_ready, 1);
    repeat (200) @(negedge clk);
    check_eq("post_reset_done", done_cnt - d0, 0);
    check_eq("post_reset_err", err_cnt - e0, 0);
    check_eq("post_reset_clk_oe", clk_oe, 0);
    present(8'hFF, 1'b0);
    check_inhibit();
    device_frame(0, fr);
    wait_idle();
    check_eq("frame_FF", fr, FR_FF);
    check_eq("done_FF", done_cnt - d0, 1);
    check_eq("err_FF", err_cnt - e0, 0);

    // two queued bytes with tx_valid held
    d0 = done_cnt; e0 = err_cnt;
    present(8'hF4, 1'b1);
    tx_data = 8'hED;
    check_inhibit();
    device_frame(0, fr);
    present(8'hED, 1'b0);
    check_eq("queue_done_first", done_cnt - d0, 1);
    check_inhibit();
    device_frame(0, fr2);
    wait_idle();
    check_eq("frame_q1_F4", fr, FR_F4);
    check_eq("frame_q2_ED", fr2, FR_ED);
    check_eq("queue_done", done_cnt - d0, 2);
    check_eq("queue_err", err_cnt - e0, 0);

    check_eq("done_error_together", both_cnt, 0);
    check_eq("ready_during_frame", ready_viol, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
